// File: rtl/led_frame_sequencer_if.sv
// Pixel-RAM read port and serializer word handshake between the frame sequencer and its neighbours.
interface led_frame_if #(
    parameter int AW = 3,
    parameter int DW = 24
);
    logic [AW-1:0] pixel_addr;
    logic          pixel_rd;
    logic [DW-1:0] pixel_data;
    logic [DW-1:0] rz_data;
    logic          rz_enable;
    logic          rz_ready;

    modport master (
        output pixel_addr, pixel_rd, rz_data, rz_enable,
        input  pixel_data, rz_ready
    );

    modport slave (
        input  pixel_addr, pixel_rd, rz_data, rz_enable,
        output pixel_data, rz_ready
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Reads one frame of pixels from RAM, scales/reorders/bit-reverses them and streams
// them to the RZ serializer, then waits out the strip latch period.
module led_frame_sequencer #(
    parameter int NUM_LEDS   = 8,
    parameter int DATA_WIDTH = 24,
    parameter int GRB_ORDER  = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [7:0]  brightness,
    output logic        busy,
    output logic        frame_done,
    led_frame_if.master bus
);
    localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int NW = $clog2(NUM_LEDS + 1);
    localparam int CW = DATA_WIDTH / 3;
    localparam int QD = 3;
    localparam logic [NW-1:0] N_LEDS   = NW'(NUM_LEDS);
    localparam logic [NW-1:0] LAST_IDX = NW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

    state_t              state_reg, state_next;
    logic [7:0]          bright_reg, bright_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                rd_reg, rd_next;
    logic                dv_reg;
    logic [AW-1:0]       addr_reg, addr_next;
    logic [NW-1:0]       issued_reg, issued_next;
    logic [NW-1:0]       sent_reg, sent_next;
    logic                low_seen_reg, low_seen_next;
    logic [1:0]          count_reg, count_next;
    logic [1:0]          wr_idx;
    logic                push, pop;
    logic [DATA_WIDTH-1:0] q_reg [QD];
    logic [DATA_WIDTH-1:0] ordered, word_in;
    logic [CW-1:0]       ch_r, ch_g, ch_b;

    function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [7:0] b);
        logic [CW+8:0] p;
        p = {9'd0, c} * ({{CW{1'b0}}, 1'b0, b} + (CW+9)'(1));
        return p[CW+7:8];
    endfunction

    always_comb begin
        ch_r    = scale(bus.pixel_data[3*CW-1 -: CW], bright_reg);
        ch_g    = scale(bus.pixel_data[2*CW-1 -: CW], bright_reg);
        ch_b    = scale(bus.pixel_data[CW-1:0], bright_reg);
        ordered = (GRB_ORDER != 0) ? {ch_g, ch_r, ch_b} : {ch_r, ch_g, ch_b};
    end

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
        assign word_in[gi] = (MSB_FIRST != 0) ? ordered[DATA_WIDTH-1-gi] : ordered[gi];
    end

    // A read lands two edges after issue, so a third word slot keeps one transfer
    // per cycle going without ever dropping a returning pixel when rz_ready stalls.
    assign push       = dv_reg;
    assign pop        = (count_reg != 2'd0) && bus.rz_ready;
    assign count_next = count_reg + 2'(push) - 2'(pop);
    assign wr_idx     = count_reg - 2'(pop);

    always_comb begin
        state_next    = state_reg;
        bright_next   = bright_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        rd_next       = 1'b0;
        addr_next     = addr_reg;
        issued_next   = issued_reg;
        sent_next     = sent_reg;
        low_seen_next = low_seen_reg;
        case (state_reg)
            IDLE: begin
                if (frame_start && !done_reg) begin
                    bright_next   = brightness;
                    busy_next     = 1'b1;
                    rd_next       = 1'b1;
                    addr_next     = '0;
                    issued_next   = NW'(1);
                    sent_next     = '0;
                    low_seen_next = 1'b0;
                    state_next    = FETCH;
                end
            end
            FETCH, SEND: begin
                if ((issued_reg < N_LEDS) && (({1'b0, count_next} + {2'b0, rd_reg}) <= 3'd2)) begin
                    rd_next     = 1'b1;
                    addr_next   = issued_reg[AW-1:0];
                    issued_next = issued_reg + NW'(1);
                end
                if (state_reg == FETCH) begin
                    if (push) state_next = SEND;
                end else if (pop) begin
                    sent_next = sent_reg + NW'(1);
                    if (sent_reg == LAST_IDX) state_next = LATCH;
                end
            end
            LATCH: begin
                if (!bus.rz_ready) begin
                    low_seen_next = 1'b1;
                end else if (low_seen_reg) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            bright_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_reg       <= 1'b0;
            dv_reg       <= 1'b0;
            addr_reg     <= '0;
            issued_reg   <= '0;
            sent_reg     <= '0;
            low_seen_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            bright_reg   <= bright_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rd_reg       <= rd_next;
            dv_reg       <= rd_reg;
            addr_reg     <= addr_next;
            issued_reg   <= issued_next;
            sent_reg     <= sent_next;
            low_seen_reg <= low_seen_next;
            count_reg    <= count_next;
        end
    end

    // Slot 0 is the output register; a pop shifts later slots down in the same edge.
    for (genvar gi = 0; gi < QD; gi++) begin : g_slot
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q_reg[gi] <= '0;
            end else if (push && (wr_idx == 2'(gi))) begin
                q_reg[gi] <= word_in;
            end else if (pop) begin
                if (gi < QD - 1) q_reg[gi] <= q_reg[(gi < QD - 1) ? gi + 1 : gi];
            end
        end
    end

    assign bus.rz_data    = q_reg[0];
    assign bus.rz_enable  = (count_reg != 2'd0);
    assign bus.pixel_rd   = rd_reg;
    assign bus.pixel_addr = addr_reg;
    assign busy           = busy_reg;
    assign frame_done     = done_reg;
endmodule
